// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin share of one mult between NUM_PORTS requesters.
// Define MULT_SHARE_ARB_PRIORITY_EN for fixed lowest-index priority instead.
module mult_share_arb #(
  parameter int NUM_PORTS      = 4,
  parameter int WIDTH_A        = 25,
  parameter int WIDTH_B        = 18,
  parameter int WIDTH_P        = 48,
  parameter int TAG_DEPTH_LOG2 = 3,
  localparam int DW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*WIDTH_A-1:0]   s_a_tdata,
  input  logic [NUM_PORTS*WIDTH_B-1:0]   s_b_tdata,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  output logic [NUM_PORTS-1:0]           s_tready,
  output logic [WIDTH_A-1:0]             m_a_tdata,
  output logic                           m_a_tlast,
  output logic                           m_a_tvalid,
  input  logic                           m_a_tready,
  output logic [WIDTH_B-1:0]             m_b_tdata,
  output logic                           m_b_tlast,
  output logic                           m_b_tvalid,
  input  logic                           m_b_tready,
  input  logic [WIDTH_P-1:0]             p_tdata,
  input  logic                           p_tlast,
  input  logic                           p_tvalid,
  output logic                           p_tready,
  output logic [WIDTH_P-1:0]             o_tdata,
  output logic                           o_tlast,
  output logic                           o_tvalid,
  output logic [DW-1:0]                  o_tdest,
  input  logic                           o_tready
);

  localparam int TW    = TAG_DEPTH_LOG2;
  localparam int DEPTH = 1 << TW;
  localparam logic [TW:0] DEPTH_C = (TW+1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  logic [DW-1:0] g;
  logic          a_done;
  logic          b_done;
  logic [DW-1:0] tag_mem [DEPTH];
  logic [TW-1:0] wr_ptr;
  logic [TW-1:0] rd_ptr;
  logic [TW:0]   count;

  logic [DW-1:0] pick;
  logic          hit;
  logic          issue;
  logic          sv_g;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          a_fire;
  logic          b_fire;
  logic          beat;
  logic          beat_last;

`ifndef MULT_SHARE_ARB_PRIORITY_EN
  logic [DW-1:0] rr;
`endif

  // Find the requester to grant: first valid port at/after rr, or lowest.
  always_comb begin
    int            idx;
    logic [DW-1:0] idx_w;
    hit   = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef MULT_SHARE_ARB_PRIORITY_EN
      idx = k;
`else
      idx = (int'(rr) + k) % NUM_PORTS;
`endif
      idx_w = idx[DW-1:0];
      if (!hit && s_tvalid[idx_w]) begin
        hit  = 1'b1;
        pick = idx_w;
      end
    end
  end

  assign issue = (state == ISSUE);
  assign sv_g  = s_tvalid[g];

  assign m_a_tvalid = issue & sv_g & ~a_done;
  assign m_b_tvalid = issue & sv_g & ~b_done;
  assign m_a_tdata  = issue ? s_a_tdata[g*WIDTH_A +: WIDTH_A] : '0;
  assign m_b_tdata  = issue ? s_b_tdata[g*WIDTH_B +: WIDTH_B] : '0;
  assign m_a_tlast  = issue & s_tlast[g];
  assign m_b_tlast  = issue & s_tlast[g];

  assign a_fire    = m_a_tvalid & m_a_tready;
  assign b_fire    = m_b_tvalid & m_b_tready;
  assign beat      = issue & (a_done | a_fire) & (b_done | b_fire);
  assign beat_last = beat & s_tlast[g];

  // Only the granted port sees ready, and only on the completing cycle.
  always_comb begin
    s_tready = '0;
    if (beat) s_tready[g] = 1'b1;
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  assign o_tvalid = p_tvalid & ~fifo_empty;
  assign p_tready = o_tready & ~fifo_empty;
  assign o_tdata  = fifo_empty ? '0 : p_tdata;
  assign o_tlast  = p_tlast & ~fifo_empty;
  assign o_tdest  = fifo_empty ? '0 : tag_mem[rd_ptr];

  assign pop  = o_tvalid & o_tready & p_tlast;
  assign push = (state == IDLE) & hit & (~fifo_full | pop);

  // Packet-locked grant FSM with split A/B handshake tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      g      <= '0;
      a_done <= 1'b0;
      b_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (push) begin
            g     <= pick;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            if (beat_last) state <= IDLE;
          end else begin
            if (a_fire) a_done <= 1'b1;
            if (b_fire) b_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULT_SHARE_ARB_PRIORITY_EN
  // Advance the round-robin pointer past the port that just finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr <= '0;
    end else if (beat_last) begin
      rr <= (g == DW'(NUM_PORTS-1)) ? '0 : g + 1'b1;
    end
  end
`endif

  // In-order tag FIFO: grant index in, destination of product packet out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= pick;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: randomized and directed checks of the mult sharer.
// Expected grant orders follow MULT_SHARE_ARB_PRIORITY_EN when defined.
module tb_mult_share_arb;

  localparam int NP = 4;
  localparam int WA = 25;
  localparam int WB = 18;
  localparam int WP = 48;
  localparam int DW = 2;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [WP-1:0] d;
    logic          last;
  } prod_t;

  typedef struct packed {
    logic [DW-1:0] dest;
    logic          last;
    logic [WP-1:0] d;
  } obs_t;

  logic             clk = 0;
  logic             reset = 0;
  logic [NP*WA-1:0] s_a_tdata = '0;
  logic [NP*WB-1:0] s_b_tdata = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tready;
  logic [WA-1:0]    m_a_tdata;
  logic             m_a_tlast, m_a_tvalid;
  logic             m_a_tready = 0;
  logic [WB-1:0]    m_b_tdata;
  logic             m_b_tlast, m_b_tvalid;
  logic             m_b_tready = 0;
  logic [WP-1:0]    p_tdata = '0;
  logic             p_tlast = 0, p_tvalid = 0;
  logic             p_tready;
  logic [WP-1:0]    o_tdata;
  logic             o_tlast, o_tvalid;
  logic [DW-1:0]    o_tdest;
  logic             o_tready = 0;

  mult_share_arb #(
    .NUM_PORTS(NP), .WIDTH_A(WA), .WIDTH_B(WB),
    .WIDTH_P(WP), .TAG_DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .reset(reset),
    .s_a_tdata(s_a_tdata), .s_b_tdata(s_b_tdata),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_a_tdata(m_a_tdata), .m_a_tlast(m_a_tlast),
    .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready),
    .m_b_tdata(m_b_tdata), .m_b_tlast(m_b_tlast),
    .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready),
    .p_tdata(p_tdata), .p_tlast(p_tlast),
    .p_tvalid(p_tvalid), .p_tready(p_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tdest(o_tdest), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  beat_t         tx_q[NP][$];
  prod_t         exp_q[NP][$];
  logic [WA:0]   a_q[$];
  logic [WB:0]   b_q[$];
  prod_t         p_q[$];
  obs_t          obs_q[$];
  int            ord_q[$];
  int            n_a, n_b, n_out, n_tot;
  int            n_rdy[NP];

  bit gap_en = 0;
  bit rand_rdy = 0;
  bit rand_p = 0;
  bit b_off = 0;
  int o_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic add_beat(input int p, input logic [WA-1:0] a,
                          input logic [WB-1:0] b, input logic last);
    beat_t bt;
    prod_t pr;
    bt.a = a;
    bt.b = b;
    bt.last = last;
    pr.d = WP'(a) * WP'(b);
    pr.last = last;
    tx_q[p].push_back(bt);
    exp_q[p].push_back(pr);
    n_tot++;
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int j = 0; j < len; j++)
      add_beat(p, WA'($urandom), WB'($urandom), j == len - 1);
  endtask

  function automatic bit model_empty();
    bit e;
    e = (a_q.size() == 0) && (b_q.size() == 0) && (p_q.size() == 0);
    for (int i = 0; i < NP; i++)
      if (tx_q[i].size() != 0 || exp_q[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      tx_q[i].delete();
      exp_q[i].delete();
    end
    a_q.delete();
    b_q.delete();
    p_q.delete();
    s_tvalid = '0;
    s_tlast = '0;
    s_a_tdata = '0;
    s_b_tdata = '0;
    p_tvalid = 0;
    p_tlast = 0;
    p_tdata = '0;
  endtask

  task automatic clear_stats();
    obs_q.delete();
    ord_q.delete();
    n_a = 0;
    n_b = 0;
    n_out = 0;
    n_tot = 0;
    n_rdy = '{default: 0};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // One clock: sample handshakes at negedge, drive new inputs after posedge.
  task automatic step();
    logic [NP-1:0] sf;
    logic          pf;
    logic [WA:0]   av;
    logic [WB:0]   bv;
    prod_t         pr;
    obs_t          ob;
    int            d;
    @(negedge clk);
    chk("s_tready_legal",
        ((s_tready & ~s_tvalid) != 0) || ($countones(s_tready) > 1), 0);
    sf = s_tvalid & s_tready;
    for (int i = 0; i < NP; i++)
      if (sf[i]) begin
        n_rdy[i]++;
        if (tx_q[i].size() > 0) void'(tx_q[i].pop_front());
      end
    if (m_a_tvalid && m_a_tready) begin
      a_q.push_back({m_a_tlast, m_a_tdata});
      n_a++;
    end
    if (m_b_tvalid && m_b_tready) begin
      b_q.push_back({m_b_tlast, m_b_tdata});
      n_b++;
    end
    pf = p_tvalid && p_tready;
    if (o_tvalid && o_tready) begin
      d = int'(o_tdest);
      n_out++;
      if (exp_q[d].size() == 0) begin
        chk("o_unexpected_beat", 1, 0);
      end else begin
        pr = exp_q[d].pop_front();
        chk("o_tdata", o_tdata, pr.d);
        chk("o_tlast", o_tlast, pr.last);
      end
      ob.dest = o_tdest;
      ob.last = o_tlast;
      ob.d = o_tdata;
      obs_q.push_back(ob);
      if (o_tlast) ord_q.push_back(d);
    end
    if (pf && p_q.size() > 0) void'(p_q.pop_front());
    @(posedge clk);
    #1;
    while (a_q.size() > 0 && b_q.size() > 0) begin
      av = a_q.pop_front();
      bv = b_q.pop_front();
      chk("ab_last_pair", av[WA], bv[WB]);
      pr.d = WP'(av[WA-1:0]) * WP'(bv[WB-1:0]);
      pr.last = av[WA];
      p_q.push_back(pr);
    end
    if (!(p_tvalid && !pf)) begin
      if (p_q.size() > 0 && (!rand_p || $urandom_range(0, 3) != 0)) begin
        p_tvalid = 1;
        p_tdata = p_q[0].d;
        p_tlast = p_q[0].last;
      end else begin
        p_tvalid = 0;
      end
    end
    m_a_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    m_b_tready = b_off ? 1'b0 :
                 (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    o_tready = (o_mode == 2) ? 1'b0 :
               (o_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < NP; i++) begin
      if (!(s_tvalid[i] && !sf[i])) begin
        if (tx_q[i].size() > 0 && (!gap_en || $urandom_range(0, 1))) begin
          s_tvalid[i] = 1;
          s_a_tdata[i*WA +: WA] = tx_q[i][0].a;
          s_b_tdata[i*WB +: WB] = tx_q[i][0].b;
          s_tlast[i] = tx_q[i][0].last;
        end else begin
          s_tvalid[i] = 0;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!model_empty() && n < budget) begin
      step();
      n++;
    end
    chk(tag, model_empty(), 1);
  endtask

  int eo[8];
  int n;

  initial begin
    // Reset state with busy-looking inputs.
    s_tvalid = '1;
    s_tlast = '1;
    s_a_tdata = {4{25'h1abcd}};
    s_b_tdata = {4{18'h2345}};
    p_tvalid = 1;
    p_tlast = 1;
    p_tdata = 48'h123456789;
    o_tready = 1;
    m_a_tready = 1;
    m_b_tready = 1;
    #12;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_a_tvalid", m_a_tvalid, 0);
    chk("rst_m_b_tvalid", m_b_tvalid, 0);
    chk("rst_p_tready", p_tready, 0);
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_m_a_tdata", m_a_tdata, 0);
    chk("rst_o_tdata", o_tdata, 0);
    chk("rst_o_tdest", o_tdest, 0);
    clear_model();
    clear_stats();
    @(posedge clk);
    #1 reset = 1;

    // Single 3-beat packet on port 0.
    add_beat(0, 1, 4, 0);
    add_beat(0, 2, 5, 0);
    add_beat(0, 3, 6, 1);
    drain("t1_drain", 200);
    chk("t1_beats", obs_q.size(), 3);
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      chk("t1_dest", obs_q[i].dest, 0);
      chk("t1_last", obs_q[i].last, i == 2);
    end
    if (obs_q.size() == 3) begin
      chk("t1_p0", obs_q[0].d, 4);
      chk("t1_p1", obs_q[1].d, 10);
      chk("t1_p2", obs_q[2].d, 18);
    end
    chk("t1_s_tready_cycles", n_rdy[0], 3);

    // All ports busy with 2-beat packets from a fresh reset.
    do_reset();
    clear_stats();
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 2);
      add_pkt(p, 2);
    end
`ifdef MULT_SHARE_ARB_PRIORITY_EN
    eo = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    eo = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    drain("t2_drain", 400);
    chk("t2_pkts", ord_q.size(), 8);
    for (int i = 0; i < ord_q.size() && i < 8; i++)
      chk("t2_order", ord_q[i], eo[i]);

    // Split handshake: B stalls while A is accepted once.
    clear_stats();
    b_off = 1;
    add_pkt(1, 2);
    repeat (7) step();
    chk("t3_a_once", n_a, 1);
    chk("t3_b_none", n_b, 0);
    chk("t3_no_ready", n_rdy[1], 0);
    b_off = 0;
    drain("t3_drain", 200);
    chk("t3_a_total", n_a, 2);
    chk("t3_b_total", n_b, 2);
    chk("t3_ready_total", n_rdy[1], 2);

    // Tag FIFO full: 8 packets in flight block the 9th.
    clear_stats();
    o_mode = 2;
    for (int i = 0; i < 9; i++) add_beat(0, WA'(i + 7), WB'(i + 3), 1);
    repeat (60) step();
    chk("t4_issued", n_a, 8);
    chk("t4_left", tx_q[0].size(), 1);
    chk("t4_no_grant", m_a_tvalid, 0);
    chk("t4_o_tvalid", o_tvalid, 1);
    o_mode = 0;
    drain("t4_drain", 300);
    chk("t4_issued_all", n_a, 9);
    chk("t4_pkts", ord_q.size(), 9);

    // Reset in the middle of a port 2 packet.
    clear_stats();
    add_pkt(1, 1);
    drain("t5_pre_drain", 200);
    add_beat(2, 25'h11, 18'h22, 0);
    add_beat(2, 25'h33, 18'h44, 0);
    add_beat(2, 25'h55, 18'h66, 1);
    n = 0;
    while (n_rdy[2] < 1 && n < 50) begin
      step();
      n++;
    end
    chk("t5_mid", n_rdy[2], 1);
    reset = 0;
    #1;
    chk("t5_s_tready", s_tready, 0);
    chk("t5_m_a_tvalid", m_a_tvalid, 0);
    chk("t5_m_b_tvalid", m_b_tvalid, 0);
    chk("t5_p_tready", p_tready, 0);
    chk("t5_o_tvalid", o_tvalid, 0);
    chk("t5_m_a_tdata", m_a_tdata, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    clear_stats();
    add_pkt(3, 1);
    add_pkt(0, 1);
    drain("t5_drain", 200);
    chk("t5_pkts", ord_q.size(), 2);
    if (ord_q.size() == 2) begin
      chk("t5_first", ord_q[0], 0);
      chk("t5_second", ord_q[1], 3);
    end

    // Randomized traffic with random backpressure everywhere.
    clear_stats();
    gap_en = 1;
    rand_rdy = 1;
    rand_p = 1;
    o_mode = 1;
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 4));
      repeat ($urandom_range(1, 20)) step();
    end
    drain("t6_drain", 20000);
    chk("t6_beats", n_out, n_tot);
    gap_en = 0;
    rand_rdy = 0;
    rand_p = 0;
    o_mode = 0;

    // Ports 1 and 3 continuously requesting.
    do_reset();
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      add_pkt(1, 1);
      add_pkt(3, 1);
    end
`ifdef MULT_SHARE_ARB_PRIORITY_EN
    eo = '{1, 1, 1, 1, 3, 3, 3, 3};
`else
    eo = '{1, 3, 1, 3, 1, 3, 1, 3};
`endif
    drain("t7_drain", 400);
    chk("t7_pkts", ord_q.size(), 8);
    for (int i = 0; i < ord_q.size() && i < 8; i++)
      chk("t7_order", ord_q[i], eo[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
